// File: rtl/simple_cpu_pkg.sv
// simple_cpu_pkg: opcodes, sequencer state encoding and default timing shared by the simple_cpu blocks
package simple_cpu_pkg;
   typedef enum logic [1:0] {OP_HALT = 2'b00, OP_ALU = 2'b01, OP_LOAD_R = 2'b10, OP_STORE_R = 2'b11} opcode_e;
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} seq_state_e;
   localparam int DEF_INSTR_WIDTH    = 20;
   localparam int DEF_PROG_ADDR_BITS = 4;
   localparam int DEF_ALU_CYCLES     = 4;
   localparam int DEF_MEM_CYCLES     = 3;
   function automatic logic [7:0] hold_cycles(input logic [1:0] op, input int alu, input int mem);
      return (op == OP_ALU) ? 8'(alu) : 8'(mem);
   endfunction
endpackage

// File: rtl/instr_rom_ram.sv
// instr_rom_ram: program store with one write port and a registered read port, never cleared by reset
module instr_rom_ram #(
   parameter int W  = 20,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);
   logic [W-1:0] r_mem [2**AW];
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      o_rdata <= r_mem[i_raddr];
   end
endmodule

// File: rtl/cpu_instr_sequencer.sv
// cpu_instr_sequencer: steps through the program store, holding each word on the
// simple_cpu instruction bus for its opcode's issue time until HALT or the last address
module cpu_instr_sequencer
   import simple_cpu_pkg::*;
#(
   parameter int INSTR_WIDTH    = DEF_INSTR_WIDTH,
   parameter int PROG_ADDR_BITS = DEF_PROG_ADDR_BITS,
   parameter int ALU_CYCLES     = DEF_ALU_CYCLES,
   parameter int MEM_CYCLES     = DEF_MEM_CYCLES
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      prog_we,
   input  logic [PROG_ADDR_BITS-1:0] prog_addr,
   input  logic [INSTR_WIDTH-1:0]    prog_wdata,
   input  logic                      start,
   input  logic                      abort,
   output logic [INSTR_WIDTH-1:0]    instruction,
   output logic [PROG_ADDR_BITS-1:0] pc,
   output logic                      busy,
   output logic                      done,
   output logic [7:0]                retired
);
   localparam logic [PROG_ADDR_BITS-1:0] PC_ONE  = 1;
   localparam logic [PROG_ADDR_BITS-1:0] PC_LAST = '1;
   seq_state_e                r_state;
   logic [PROG_ADDR_BITS-1:0] r_pc;
   logic [INSTR_WIDTH-1:0]    r_instr;
   logic [7:0]                r_cnt;
   logic [7:0]                r_retired;
   logic                      r_busy;
   logic                      r_done;
   logic                      w_we;
   logic [PROG_ADDR_BITS-1:0] w_raddr;
   logic [INSTR_WIDTH-1:0]    w_rdata;
   logic [1:0]                w_op;
   assign w_we    = prog_we && (r_state == S_IDLE || r_state == S_DONE);
   // FETCH is only entered from a start (pc=0) or from the last ISSUE cycle (pc+1),
   // so the registered read is pointed at the address FETCH will need
   assign w_raddr = (r_state == S_ISSUE) ? r_pc + PC_ONE : '0;
   assign w_op    = w_rdata[INSTR_WIDTH-1 -: 2];
   instr_rom_ram #(.W(INSTR_WIDTH), .AW(PROG_ADDR_BITS)) u_store (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (prog_addr),
      .i_wdata (prog_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_pc      <= '0;
         r_instr   <= '0;
         r_cnt     <= '0;
         r_retired <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else if (abort && r_state != S_IDLE) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
         r_instr <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: if (start) begin
               r_state   <= S_FETCH;
               r_pc      <= '0;
               r_retired <= '0;
               r_busy    <= 1'b1;
               r_done    <= 1'b0;
            end
            S_FETCH: if (w_op == OP_HALT) begin
               r_state <= S_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end else begin
               r_state <= S_ISSUE;
               r_instr <= w_rdata;
               r_cnt   <= hold_cycles(w_op, ALU_CYCLES, MEM_CYCLES);
            end
            S_ISSUE: begin
               r_cnt <= r_cnt - 8'd1;
               if (r_cnt == 8'd1) begin
                  r_instr <= '0;
                  if (r_retired != 8'hFF) r_retired <= r_retired + 8'd1;
                  if (r_pc == PC_LAST) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_FETCH;
                     r_pc    <= r_pc + PC_ONE;
                  end
               end
            end
         endcase
      end
   end
   assign instruction = r_instr;
   assign pc          = r_pc;
   assign busy        = r_busy;
   assign done        = r_done;
   assign retired     = r_retired;
endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// tb_cpu_instr_sequencer: directed runs of cpu_instr_sequencer; expected issue/done/abort
// events are queued by the stimulus and matched by a negedge monitor
module tb_cpu_instr_sequencer;
   logic        clk = 1'b0;
   logic        rst, prog_we, start, abort;
   logic [3:0]  prog_addr;
   logic [19:0] prog_wdata;
   logic [19:0] instruction;
   logic [3:0]  pc;
   logic        busy, done;
   logic [7:0]  retired;

   cpu_instr_sequencer dut (
      .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
      .start(start), .abort(abort), .instruction(instruction), .pc(pc), .busy(busy),
      .done(done), .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct {int kind; logic [31:0] word; int n;} ev_t;
   ev_t exp_q[$];
   int tests = 0;
   int fails = 0;
   string kname[3] = '{"issue", "done", "abort"};
   logic [19:0] p1[5] = '{20'h47000, 20'h53000, 20'h72001, 20'hD80F0, 20'h00000};
   int p1_hold[4] = '{4, 4, 4, 3};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_ev(input int k, input logic [31:0] w, input int n);
      ev_t e;
      e.kind = k;
      e.word = w;
      e.n = n;
      exp_q.push_back(e);
   endtask

   task automatic push_p1();
      for (int i = 0; i < 4; i++) push_ev(0, 32'(p1[i]), p1_hold[i]);
      push_ev(1, 32'd4, 4);
   endtask

   task automatic sb_check(input int k, input logic [31:0] w, input int n);
      ev_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_%s: got %0h/%0d expected no event", kname[k], w, n);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.word !== w || e.n != n) begin
            fails++;
            $display("FAIL event_%s: got %s %0h/%0d expected %s %0h/%0d",
                     kname[e.kind], kname[k], w, n, kname[e.kind], e.word, e.n);
         end
      end
   endtask

   logic [19:0] prev_instr = '0;
   logic        prev_busy = 1'b0;
   logic        prev_done = 1'b0;
   int          run_len = 0;

   always @(negedge clk) begin
      if (prev_instr != '0 && instruction != prev_instr) sb_check(0, 32'(prev_instr), run_len);
      if (instruction != '0) run_len = (instruction == prev_instr) ? run_len + 1 : 1;
      else run_len = 0;
      if (done && !prev_done) sb_check(1, 32'(pc), int'(retired));
      if (prev_busy && !busy && !done) sb_check(2, 32'(pc), int'(retired));
      prev_instr = instruction;
      prev_busy  = busy;
      prev_done  = done;
   end

   task automatic prog_write(input logic [3:0] a, input logic [19:0] d);
      prog_we = 1'b1;
      prog_addr = a;
      prog_wdata = d;
      @(posedge clk);
      #1 prog_we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && !done; i++) begin
         @(posedge clk);
         #1;
      end
      chk("done_within_budget", 32'(done), 32'd1);
   endtask

   function automatic logic [19:0] full_word(input int i);
      logic [1:0] op;
      op = 2'((i % 3) + 1);
      return {op, 18'(i * 37 + 1)};
   endfunction

   initial begin
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      prog_we = 1'b0;
      prog_addr = '0;
      prog_wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_instruction", 32'(instruction), 32'd0);
      chk("reset_pc", 32'(pc), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_retired", 32'(retired), 32'd0);
      for (int i = 0; i < 5; i++) prog_write(4'(i), p1[i]);

      push_p1();
      pulse_start();
      wait_done(100);
      repeat (3) @(posedge clk);
      #1;
      chk("done_holds", 32'(done), 32'd1);
      chk("done_pc", 32'(pc), 32'd4);

      push_p1();
      pulse_start();
      @(posedge clk);
      #1;
      start = 1'b1;
      prog_we = 1'b1;
      prog_addr = 4'd1;
      prog_wdata = 20'h00000;
      @(posedge clk);
      #1;
      start = 1'b0;
      prog_we = 1'b0;
      chk("start_in_issue_busy", 32'(busy), 32'd1);
      chk("start_in_issue_instr", 32'(instruction), 32'h47000);
      wait_done(100);
      chk("ignored_write_retired", 32'(retired), 32'd4);

      push_ev(0, 32'h47000, 4);
      push_ev(0, 32'h53000, 2);
      push_ev(2, 32'd0, 1);
      pulse_start();
      repeat (7) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      chk("abort_instruction", 32'(instruction), 32'd0);
      chk("abort_pc", 32'(pc), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_retired", 32'(retired), 32'd1);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      chk("idle_abort_retired", 32'(retired), 32'd1);
      chk("idle_abort_busy", 32'(busy), 32'd0);

      push_p1();
      pulse_start();
      wait_done(100);
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_done", 32'(done), 32'd0);
      chk("start_abort_busy", 32'(busy), 32'd0);
      chk("start_abort_pc", 32'(pc), 32'd0);
      chk("start_abort_retired", 32'(retired), 32'd4);
      push_p1();
      pulse_start();
      chk("rerun_retired", 32'(retired), 32'd0);
      chk("rerun_busy", 32'(busy), 32'd1);
      chk("rerun_pc", 32'(pc), 32'd0);
      wait_done(100);

      push_ev(0, 32'h47000, 1);
      push_ev(2, 32'd0, 0);
      pulse_start();
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_instruction", 32'(instruction), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      push_p1();
      pulse_start();
      wait_done(100);

      for (int i = 0; i < 16; i++) begin
         prog_write(4'(i), full_word(i));
         push_ev(0, 32'(full_word(i)), (i % 3) == 0 ? 4 : 3);
      end
      push_ev(1, 32'd15, 16);
      pulse_start();
      wait_done(200);
      chk("full_pc", 32'(pc), 32'd15);
      chk("full_retired", 32'(retired), 32'd16);

      prog_write(4'd0, 20'h00000);
      push_ev(1, 32'd0, 0);
      pulse_start();
      @(posedge clk);
      #1;
      chk("halt_one_cycle_done", 32'(done), 32'd1);
      chk("halt_retired", 32'(retired), 32'd0);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
